// File: rtl/qkt_score_serializer_pkg.sv
// Shared constants and types for the Q*K^T score serializer.
// Holds the tile geometry, the beat geometry derived from it, the per-bank
// state encoding and a helper that tells whether a tile beat index closes a
// word. Optional feature macro used by the top: QKT_SCORE_SCALE_EN.
package qkt_score_serializer_pkg;

  localparam int WIDTH_OUT     = 16;
  localparam int CHUNK_SIZE    = 4;
  localparam int NUM_CORES_A   = 2;
  localparam int NUM_CORES_B   = 1;
  localparam int TOTAL_MODULES = 1;
  localparam int TOTAL_INPUT_W = 2;
  localparam int BEAT_ELEMS    = 4;
  localparam int SCALE_SHIFT   = 3;

  localparam int SCORE_IN_W   = WIDTH_OUT * CHUNK_SIZE * NUM_CORES_A * NUM_CORES_B * TOTAL_MODULES;
  localparam int SCORE_BEAT_W = WIDTH_OUT * BEAT_ELEMS;
  localparam int SCORE_BPW    = SCORE_IN_W / SCORE_BEAT_W;
  localparam int SCORE_BPT    = SCORE_BPW * TOTAL_INPUT_W;
  localparam int SCORE_TILE_W = SCORE_IN_W * TOTAL_INPUT_W;

  // Width of the beat-within-tile counter (at least one bit).
  localparam int SCORE_BCW = (SCORE_BPT > 1) ? $clog2(SCORE_BPT) : 1;
  localparam logic [SCORE_BCW-1:0] SCORE_LAST_IDX = SCORE_BCW'(SCORE_BPT - 1);

  typedef enum logic [1:0] {
    BANK_EMPTY = 2'd0,
    BANK_FULL  = 2'd1,
    BANK_DRAIN = 2'd2
  } score_bank_state_t;

  typedef logic [SCORE_BEAT_W-1:0] score_beat_t;

  // True when tile beat index idx is the last slice of its word.
  function automatic logic score_is_wlast(input int idx);
    return (idx % SCORE_BPW) == (SCORE_BPW - 1);
  endfunction

endpackage

// File: rtl/qkt_score_serializer_round_shift.sv
// Per-element 1/sqrt(dk) scaling: signed arithmetic right shift by
// SCALE_SHIFT with round-half-up, saturating to the signed maximum.
// Ports:
//   elem_i  signed score element in
//   elem_o  scaled, rounded, saturated element out
// Purely combinational; used by the top only when QKT_SCORE_SCALE_EN is set.
module qkt_score_serializer_round_shift
  import qkt_score_serializer_pkg::*;
(
  input  logic [WIDTH_OUT-1:0] elem_i,
  output logic [WIDTH_OUT-1:0] elem_o
);

  // One guard bit so that adding the rounding constant cannot wrap.
  localparam int EW     = WIDTH_OUT + 1;
  localparam int RND_SH = (SCALE_SHIFT > 0) ? SCALE_SHIFT - 1 : 0;
  localparam logic signed [EW-1:0] RND  = (SCALE_SHIFT > 0) ? EW'(1 << RND_SH) : '0;
  localparam logic signed [EW-1:0] MAXV = {2'b00, {(WIDTH_OUT-1){1'b1}}};

  logic signed [EW-1:0] ext;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] shr;

  always_comb begin
    ext = {elem_i[WIDTH_OUT-1], elem_i};
    sum = ext + RND;
    shr = sum >>> SCALE_SHIFT;
    // Shifting only shrinks magnitude, so only the positive side can exceed range.
    if (shr > MAXV) elem_o = MAXV[WIDTH_OUT-1:0];
    else            elem_o = shr[WIDTH_OUT-1:0];
  end

endmodule

// File: rtl/qkt_score_serializer.sv
// Captures finished Q*K^T score tiles into two ping-pong banks and streams
// them out as narrow beats toward softmax, decoupling the matmul finish
// pulse from softmax back-pressure.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     tile-finish strobe; in_data holds TOTAL_INPUT_W words,
//                word w at in_data[w*IN_W +: IN_W]
//   in_ready     the write bank is empty
//   out_valid/out_ready/out_data   beat stream, out_wlast/out_tlast mark
//                the last beat of a word / of a tile
//   overflow     sticky: a strobe arrived while in_ready was low
//   tile_cnt     tiles fully drained (wraps)
// Handshake: a beat transfers on a clock edge where out_valid && out_ready;
// out_data/out_wlast/out_tlast hold while out_valid && !out_ready. A tile is
// taken on an edge where in_valid && in_ready; in_valid is a strobe and is
// not held by the producer.
// Macro QKT_SCORE_SCALE_EN: scale each element by >>> SCALE_SHIFT with
// round-half-up and saturation on the out_data register path.
module qkt_score_serializer
  import qkt_score_serializer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  logic [SCORE_TILE_W-1:0] in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SCORE_BEAT_W-1:0] out_data,
  output logic                    out_wlast,
  output logic                    out_tlast,
  output logic                    overflow,
  output logic [15:0]             tile_cnt
);

  score_bank_state_t     bank_st_q   [2];
  logic [SCORE_TILE_W-1:0] bank_data_q [2];
  logic                  wr_ptr_q;
  logic                  rd_ptr_q;
  logic [SCORE_BCW-1:0]  beat_cnt_q;  // next beat of the read bank to load
  logic                  out_valid_q;
  score_beat_t           out_data_q;
  logic                  out_wlast_q;
  logic                  out_tlast_q;
  logic                  overflow_q;
  logic [15:0]           tile_cnt_q;

  logic                    cap;
  logic                    tlast_acc;
  logic                    ld;
  logic                    ld_byp;   // load beat 0 straight from in_data
  logic                    ld_bank;
  logic [SCORE_BCW-1:0]    ld_idx;
  logic [SCORE_TILE_W-1:0] ld_tile;
  score_beat_t             ld_beat;
  score_beat_t             beat_scaled;

  assign in_ready = (bank_st_q[wr_ptr_q] == BANK_EMPTY);

  // Decide whether the output register loads a beat this edge and from where.
  always_comb begin
    cap       = in_valid && in_ready;
    tlast_acc = out_valid_q && out_ready && out_tlast_q;
    ld        = 1'b0;
    ld_byp    = 1'b0;
    ld_bank   = rd_ptr_q;
    ld_idx    = beat_cnt_q;
    if (out_valid_q && out_tlast_q) begin
      // Tile ending: chain straight into the other bank so no bubble appears.
      if (out_ready) begin
        ld_bank = ~rd_ptr_q;
        ld_idx  = '0;
        if (bank_st_q[~rd_ptr_q] == BANK_FULL) begin
          ld = 1'b1;
        end else if (cap && (wr_ptr_q != rd_ptr_q)) begin
          ld     = 1'b1;
          ld_byp = 1'b1;
        end
      end
    end else if (!out_valid_q || out_ready) begin
      if (bank_st_q[rd_ptr_q] != BANK_EMPTY) begin
        ld = 1'b1;
      end else if (cap && (wr_ptr_q == rd_ptr_q)) begin
        // Idle reader: present beat 0 the cycle after capture.
        ld     = 1'b1;
        ld_byp = 1'b1;
        ld_idx = '0;
      end
    end
    ld_tile = ld_byp ? in_data : bank_data_q[ld_bank];
    ld_beat = ld_tile[ld_idx*SCORE_BEAT_W +: SCORE_BEAT_W];
  end

`ifdef QKT_SCORE_SCALE_EN
  for (genvar e = 0; e < BEAT_ELEMS; e++) begin : g_scale
    qkt_score_serializer_round_shift u_round_shift (
      .elem_i (ld_beat[e*WIDTH_OUT +: WIDTH_OUT]),
      .elem_o (beat_scaled[e*WIDTH_OUT +: WIDTH_OUT])
    );
  end
`else
  assign beat_scaled = ld_beat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_st_q[0]   <= BANK_EMPTY;
      bank_st_q[1]   <= BANK_EMPTY;
      bank_data_q[0] <= '0;
      bank_data_q[1] <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      beat_cnt_q     <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_wlast_q    <= 1'b0;
      out_tlast_q    <= 1'b0;
      overflow_q     <= 1'b0;
      tile_cnt_q     <= '0;
    end else begin
      // Capture, load and free always target three different banks/cases,
      // so these updates never collide on one entry.
      if (cap) begin
        bank_data_q[wr_ptr_q] <= in_data;
        bank_st_q[wr_ptr_q]   <= ld_byp ? BANK_DRAIN : BANK_FULL;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (ld && !ld_byp && (bank_st_q[ld_bank] == BANK_FULL)) begin
        bank_st_q[ld_bank] <= BANK_DRAIN;
      end
      if (tlast_acc) begin
        bank_st_q[rd_ptr_q] <= BANK_EMPTY;
        rd_ptr_q            <= ~rd_ptr_q;
        tile_cnt_q          <= tile_cnt_q + 16'd1;
      end
      if (in_valid && !in_ready) begin
        overflow_q <= 1'b1;
      end
      if (ld) begin
        out_valid_q <= 1'b1;
        out_data_q  <= beat_scaled;
        out_wlast_q <= score_is_wlast(int'(ld_idx));
        out_tlast_q <= (ld_idx == SCORE_LAST_IDX);
        beat_cnt_q  <= (ld_idx == SCORE_LAST_IDX) ? '0 : ld_idx + SCORE_BCW'(1);
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_wlast = out_wlast_q;
  assign out_tlast = out_tlast_q;
  assign overflow  = overflow_q;
  assign tile_cnt  = tile_cnt_q;

endmodule
